// File: rtl/nurse_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// nurse_alarm_ctrl
//
// Purpose: alarm sequencer for a three-ward nurse call panel. A prioritized
// ward code from the upstream calling stage raises a beeping alert, shows the
// ward digit on a 7-segment display and, if nobody acknowledges within the
// escalation window, raises a supervisor alarm with a steady buzzer.
//
// Ports:
//   clk        in   single clock, all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   call_code  in   [2:0] 001 = ward 1 (highest), 010 = ward 2, 100 = ward 3,
//                   000 = no call, any other value is ignored
//   ack        in   nurse acknowledge button, clean, level-high
//   buzzer     out  buzzer drive, active-high
//   seg        out  [6:0] {g,f,e,d,c,b,a}, active-low
//   escalate   out  supervisor alarm, active-high
//   ward       out  [1:0] latched ward number, 0 = none
// -----------------------------------------------------------------------------
module nurse_alarm_ctrl #(
  parameter logic [23:0] TICK_MAX   = 24'd4999999,
  parameter logic [7:0]  BEEP_TICKS = 8'd5,
  parameter logic [9:0]  ESC_TICKS  = 10'd300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] call_code,
  input  logic       ack,
  output logic       buzzer,
  output logic [6:0] seg,
  output logic       escalate,
  output logic [1:0] ward
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALERT    = 2'd1,
    ST_ESCALATE = 2'd2,
    ST_ACKED    = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One-hot ward code to ward number; invalid or empty codes map to 0.
  function automatic logic [1:0] code_to_ward(input logic [2:0] code);
    logic [1:0] w;
    case (code)
      3'b001:  w = 2'd1;
      3'b010:  w = 2'd2;
      3'b100:  w = 2'd3;
      default: w = 2'd0;
    endcase
    return w;
  endfunction

  // Active-low digit pattern for a ward number; 0 gives a blank display.
  function automatic logic [6:0] ward_to_seg(input logic [1:0] w);
    logic [6:0] s;
    case (w)
      2'd1:    s = 7'b1111001;
      2'd2:    s = 7'b0100100;
      2'd3:    s = 7'b0110000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  ward_q, ward_d;
  logic [23:0] pre_q, pre_d;
  logic [7:0]  beep_q, beep_d;
  logic [9:0]  esc_q, esc_d;
  logic        ack_prev_q;
  logic        buzzer_q, buzzer_d;
  logic        escalate_q, escalate_d;
  logic [6:0]  seg_q, seg_d;

  logic [1:0]  code_ward_s;
  logic        code_valid_s;
  logic        higher_s;
  logic        ack_edge_s;
  logic        tick_s;
  logic        restart_s;

  assign code_ward_s  = code_to_ward(call_code);
  assign code_valid_s = (code_ward_s != 2'd0);
  // Smaller ward number means higher priority.
  assign higher_s     = code_valid_s && (code_ward_s < ward_q);
  assign ack_edge_s   = ack & ~ack_prev_q;
  assign tick_s       = (pre_q == TICK_MAX);

  // Next-state, counter and output decode.
  always_comb begin
    state_d    = state_q;
    ward_d     = ward_q;
    beep_d     = beep_q;
    esc_d      = esc_q;
    buzzer_d   = buzzer_q;
    escalate_d = 1'b0;
    seg_d      = SEG_BLANK;
    pre_d      = 24'd0;
    // restart_s re-arms the beep/escalation timing without a state change
    // (higher-priority relatch while already in ALERT).
    restart_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (code_valid_s) begin
          state_d  = ST_ALERT;
          ward_d   = code_ward_s;
          buzzer_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ALERT: begin
        if (higher_s) begin
          ward_d    = code_ward_s;
          buzzer_d  = 1'b1;
          restart_s = 1'b1;
        end else if (ack_edge_s) begin
          state_d = ST_ACKED;
        end else if (tick_s) begin
          esc_d = esc_q + 10'd1;
          if (esc_q == ESC_TICKS - 10'd1) begin
            state_d = ST_ESCALATE;
          end else begin
            state_d = ST_ALERT;
          end
          if (beep_q == BEEP_TICKS - 8'd1) begin
            beep_d   = 8'd0;
            buzzer_d = ~buzzer_q;
          end else begin
            beep_d = beep_q + 8'd1;
          end
        end else begin
          state_d = ST_ALERT;
        end
      end

      ST_ESCALATE: begin
        if (higher_s) begin
          state_d  = ST_ALERT;
          ward_d   = code_ward_s;
          buzzer_d = 1'b1;
        end else if (ack_edge_s) begin
          state_d = ST_ACKED;
        end else begin
          state_d = ST_ESCALATE;
        end
      end

      ST_ACKED: begin
        if (call_code == 3'b000) begin
          state_d = ST_IDLE;
          ward_d  = 2'd0;
        end else if (code_valid_s && (code_ward_s != ward_q)) begin
          state_d  = ST_ALERT;
          ward_d   = code_ward_s;
          buzzer_d = 1'b1;
        end else begin
          state_d = ST_ACKED;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ward_d  = 2'd0;
      end
    endcase

    // Timing restarts from zero on any state change or relatch.
    if ((state_d != state_q) || restart_s) begin
      pre_d  = 24'd0;
      beep_d = 8'd0;
      esc_d  = 10'd0;
    end else if (tick_s) begin
      pre_d = 24'd0;
    end else begin
      pre_d = pre_q + 24'd1;
    end

    // Outputs follow the state being entered so they are registered with
    // one cycle of latency.
    case (state_d)
      ST_IDLE: begin
        buzzer_d = 1'b0;
        seg_d    = SEG_BLANK;
      end
      ST_ALERT: begin
        // Display blinks in phase with the beep.
        if (buzzer_d) begin
          seg_d = ward_to_seg(ward_d);
        end else begin
          seg_d = SEG_BLANK;
        end
      end
      ST_ESCALATE: begin
        buzzer_d   = 1'b1;
        escalate_d = 1'b1;
        seg_d      = ward_to_seg(ward_d);
      end
      ST_ACKED: begin
        buzzer_d = 1'b0;
        seg_d    = ward_to_seg(ward_d);
      end
      default: begin
        buzzer_d = 1'b0;
        seg_d    = SEG_BLANK;
      end
    endcase
  end

  // State, counters, ack history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ward_q     <= 2'd0;
      pre_q      <= 24'd0;
      beep_q     <= 8'd0;
      esc_q      <= 10'd0;
      ack_prev_q <= 1'b0;
      buzzer_q   <= 1'b0;
      escalate_q <= 1'b0;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      ward_q     <= ward_d;
      pre_q      <= pre_d;
      beep_q     <= beep_d;
      esc_q      <= esc_d;
      ack_prev_q <= ack;
      buzzer_q   <= buzzer_d;
      escalate_q <= escalate_d;
      seg_q      <= seg_d;
    end
  end

  assign buzzer   = buzzer_q;
  assign seg      = seg_q;
  assign escalate = escalate_q;
  assign ward     = ward_q;

endmodule

// File: tb/tb_nurse_alarm_ctrl.sv
module tb_nurse_alarm_ctrl;

  localparam int TP  = 4;   // clocks per base tick (TICK_MAX + 1)
  localparam int BP  = 2;   // ticks per buzzer half-period
  localparam int ESC = 6;   // ticks before escalation

  localparam int M_IDLE  = 0;
  localparam int M_ALERT = 1;
  localparam int M_ESC   = 2;
  localparam int M_ACKED = 3;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk;
  logic       rst;
  logic [2:0] call_code;
  logic       ack;
  logic       buzzer;
  logic [6:0] seg;
  logic       escalate;
  logic [1:0] ward;

  nurse_alarm_ctrl #(
    .TICK_MAX  (24'd3),
    .BEEP_TICKS(8'd2),
    .ESC_TICKS (10'd6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .call_code(call_code),
    .ack      (ack),
    .buzzer   (buzzer),
    .seg      (seg),
    .escalate (escalate),
    .ward     (ward)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  string cur_tag = "init";

  // Reference model state
  int m_st = M_IDLE;
  int m_ward = 0;
  int m_c = 0;           // clocks spent in ALERT since entry/relatch
  bit m_ack_prev = 1'b0;

  logic [10:0] exp_q[$]; // {buzzer, seg, escalate, ward}

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit(input int w);
    case (w)
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      default: return BLANK;
    endcase
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic [2:0] code, input logic a, input logic r);
    int w;
    bit ed;
    w  = (code == 3'b001) ? 1 : (code == 3'b010) ? 2 : (code == 3'b100) ? 3 : 0;
    ed = a && !m_ack_prev;
    m_ack_prev = r ? 1'b0 : a;
    if (r) begin
      m_st = M_IDLE; m_ward = 0; m_c = 0;
    end else begin
      case (m_st)
        M_IDLE: if (w != 0) begin m_st = M_ALERT; m_ward = w; m_c = 0; end
        M_ALERT: begin
          if (w != 0 && w < m_ward) begin m_ward = w; m_c = 0; end
          else if (ed) m_st = M_ACKED;
          else begin
            m_c++;
            if (m_c == TP * ESC) m_st = M_ESC;
          end
        end
        M_ESC: begin
          if (w != 0 && w < m_ward) begin m_st = M_ALERT; m_ward = w; m_c = 0; end
          else if (ed) m_st = M_ACKED;
        end
        M_ACKED: begin
          if (code == 3'b000) begin m_st = M_IDLE; m_ward = 0; end
          else if (w != 0 && w != m_ward) begin m_st = M_ALERT; m_ward = w; m_c = 0; end
        end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  function automatic logic [10:0] model_out();
    logic b;
    case (m_st)
      M_ALERT: begin
        b = ((m_c / (TP * BP)) % 2) == 0;
        return {b, b ? digit(m_ward) : BLANK, 1'b0, 2'(m_ward)};
      end
      M_ESC:   return {1'b1, digit(m_ward), 1'b1, 2'(m_ward)};
      M_ACKED: return {1'b0, digit(m_ward), 1'b0, 2'(m_ward)};
      default: return {1'b0, BLANK, 1'b0, 2'(m_ward)};
    endcase
  endfunction

  // Drive one cycle, push the expected response, then pop and compare it.
  task automatic step(input logic [2:0] code, input logic a, input logic r);
    logic [10:0] exp;
    call_code = code;
    ack       = a;
    rst       = r;
    model_edge(code, a, r);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check_eq(cur_tag, {5'd0, buzzer, seg, escalate, ward}, {5'd0, exp});
  endtask

  task automatic steps(input int n, input logic [2:0] code, input logic a);
    for (int i = 0; i < n; i++) step(code, a, 1'b0);
  endtask

  initial begin
    rst = 1'b1; call_code = 3'b000; ack = 1'b0;

    // Reset state
    cur_tag = "reset";
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b1);
    check_eq("reset_out", {5'd0, buzzer, seg, escalate, ward}, {5'd0, 1'b0, BLANK, 1'b0, 2'd0});

    // Ward 2 call, beep timing and escalation after 24 clocks
    cur_tag = "alert_w2";
    step(3'b010, 1'b0, 1'b0);
    check_eq("entry_w2", {5'd0, buzzer, seg, escalate, ward}, {5'd0, 1'b1, 7'b0100100, 1'b0, 2'd2});
    for (int i = 1; i <= 26; i++) begin
      step(3'b010, 1'b0, 1'b0);
      if (i == 7)  check_eq("beep_hi_7", {15'd0, buzzer}, 16'd1);
      if (i == 8)  check_eq("beep_lo_8", {9'd0, buzzer, seg}, {9'd0, 1'b0, BLANK});
      if (i == 16) check_eq("beep_hi_16", {15'd0, buzzer}, 16'd1);
      if (i == 23) check_eq("no_esc_23", {15'd0, escalate}, 16'd0);
      if (i == 24) check_eq("esc_24", {14'd0, escalate, buzzer}, {14'd0, 2'b11});
    end

    // Invalid codes in ESCALATE, then reset mid-alarm with a call held
    cur_tag = "inv_esc";
    steps(3, 3'b011, 1'b0);
    steps(3, 3'b111, 1'b0);
    cur_tag = "rst_esc";
    step(3'b001, 1'b0, 1'b1);
    check_eq("rst_mid", {5'd0, buzzer, seg, escalate, ward}, {5'd0, 1'b0, BLANK, 1'b0, 2'd0});
    step(3'b001, 1'b0, 1'b0);
    check_eq("post_rst_w1", {13'd0, buzzer, ward}, {13'd0, 1'b1, 2'd1});

    // Priority relatch 3 -> 1 restarts escalation
    cur_tag = "relatch";
    step(3'b000, 1'b0, 1'b1);
    step(3'b100, 1'b0, 1'b0);
    steps(10, 3'b100, 1'b0);
    steps(2, 3'b010, 1'b0);   // ward 2 beats 3
    step(3'b001, 1'b0, 1'b0);
    check_eq("relatch_w1", {14'd0, ward}, 16'd1);
    for (int i = 1; i <= 24; i++) begin
      step(3'b000, 1'b0, 1'b0);
      if (i == 23) check_eq("restart_23", {15'd0, escalate}, 16'd0);
    end
    check_eq("restart_24", {15'd0, escalate}, 16'd1);

    // Long ack counts once; same code held stays ACKED; then clear
    cur_tag = "ack_hold";
    step(3'b000, 1'b0, 1'b1);
    step(3'b010, 1'b0, 1'b0);
    steps(3, 3'b010, 1'b0);
    steps(3, 3'b011, 1'b0);   // invalid code in ALERT
    steps(20, 3'b010, 1'b1);
    check_eq("acked", {8'd0, buzzer, seg}, {8'd0, 1'b0, 7'b0100100});
    steps(3, 3'b111, 1'b0);   // invalid code in ACKED
    step(3'b000, 1'b0, 1'b0);
    check_eq("to_idle", {5'd0, buzzer, seg, escalate, ward}, {5'd0, 1'b0, BLANK, 1'b0, 2'd0});
    steps(3, 3'b011, 1'b0);   // invalid code in IDLE

    // Ack and escalation in the same cycle: ack wins
    cur_tag = "ack_vs_esc";
    step(3'b001, 1'b0, 1'b0);
    steps(23, 3'b001, 1'b0);
    step(3'b001, 1'b1, 1'b0);
    check_eq("ack_wins", {14'd0, escalate, buzzer}, 16'd0);

    // ACKED ward 1, new call ward 3 relatches to ALERT
    cur_tag = "acked_relatch";
    step(3'b100, 1'b0, 1'b0);
    check_eq("acked_w3", {13'd0, buzzer, ward}, {13'd0, 1'b1, 2'd3});

    // Random traffic against the model
    cur_tag = "random";
    for (int i = 0; i < 300; i++) begin
      logic [2:0] c;
      logic a;
      logic r;
      c = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(c, a, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
